result_pack_buffer: RTL and testbench

- Parametrised successor to the single-lane FP16 result buffer. Sits between the compute engine's result output and the host/DMA read path.
- Accepts one ELEM_WIDTH result per cycle and packs PACK results into one wide word, lane 0 in the LSBs.
- Stores packed words in a dual-port BRAM FIFO with first-word-fall-through reads.
- Adds: flush of partial words with a lane-count sideband, a programmable almost-full margin, and sticky overflow/underflow error flags.

---
 rtl/result_pack_buffer_pkg.sv | 23 ++
 rtl/result_pack_store.sv | 39 +++
 rtl/result_pack_buffer.sv | 159 +++++++++++++++
 tb/tb_result_pack_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pack_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_pack_buffer_pkg
// Description : Shared defaults and the stored-word layout for the result
//               pack buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package result_pack_buffer_pkg;

  localparam int result_elem_w_gp = 16;
  localparam int result_pack_gp   = 4;
  localparam int result_words_gp  = 512;
  localparam int result_afull_gp  = 8;
  localparam int result_lane_w_gp = $clog2(result_pack_gp + 1);

  // Layout of one storage entry at the default geometry: lane count above data.
  typedef struct packed {
    logic [result_lane_w_gp-1:0]                 lanes;
    logic [result_elem_w_gp*result_pack_gp-1:0] data;
  } result_word_t;

endpackage
`default_nettype wire

// File: rtl/result_pack_store.sv
`default_nettype none
// ============================================================================
// Module      : result_pack_store
// Description : Simple dual-port RAM, one write and one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module result_pack_store
  import result_pack_buffer_pkg::*;
#(
  parameter int DATA_W = result_elem_w_gp * result_pack_gp + result_lane_w_gp,
  parameter int DEPTH  = result_words_gp,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write on a same-address collision; no reset so it maps to BRAM.
  always_ff @(posedge i_clk) begin
    r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule
`default_nettype wire

// File: rtl/result_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : result_pack_buffer
// Description : Packs PACK result elements per word into a FWFT BRAM FIFO with
//               flush, almost-full and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module result_pack_buffer
  import result_pack_buffer_pkg::*;
#(
  parameter int ELEM_WIDTH   = result_elem_w_gp,
  parameter int PACK         = result_pack_gp,
  parameter int DEPTH        = result_words_gp,
  parameter int AFULL_MARGIN = result_afull_gp,
  parameter int WORD_W       = ELEM_WIDTH * PACK,
  parameter int LANE_W       = $clog2(PACK + 1),
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ELEM_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_en,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_afull,
  output logic [WORD_W-1:0]     o_rd_data,
  output logic [LANE_W-1:0]     o_rd_lanes,
  input  logic                  i_rd_en,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_word_count,
  output logic [LANE_W-1:0]     o_pend_lanes,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int                c_aw        = $clog2(DEPTH);
  localparam int                c_ram_w     = WORD_W + LANE_W;
  localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(PACK - 1);
  localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_afull_lvl = CNT_W'(DEPTH - AFULL_MARGIN);

  logic [ELEM_WIDTH-1:0] r_pack [PACK];
  logic [LANE_W-1:0]     r_pend;
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_head_valid;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_pop;
  logic                  w_underrun;
  logic                  w_complete;
  logic                  w_push_req;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [LANE_W-1:0]     w_push_lanes;
  logic [WORD_W-1:0]     w_push_data;
  logic [CNT_W-1:0]      w_count_next;
  logic [CNT_W-1:0]      w_avail;
  logic [c_aw-1:0]       w_rd_addr;
  logic [c_ram_w-1:0]    w_ram_q;

  assign w_pop        = i_rd_en & r_head_valid;
  assign w_underrun   = i_rd_en & ~r_head_valid;
  assign w_complete   = i_wr_en & (r_pend == c_last_lane);
  assign w_push_req   = w_complete | (i_flush & (i_wr_en | (r_pend != '0)));
  assign w_push_ok    = w_push_req & ((r_count != c_depth) | w_pop);
  assign w_drop       = w_push_req & ~w_push_ok;
  assign w_push_lanes = r_pend + LANE_W'(i_wr_en);

  // Lanes at or above the pending count are forced to zero on every push.
  always_comb begin
    w_push_data = '0;
    for (int j = 0; j < PACK; j++) begin
      if (i_wr_en && (LANE_W'(j) == r_pend)) begin
        w_push_data[j*ELEM_WIDTH +: ELEM_WIDTH] = i_wr_data;
      end else if (LANE_W'(j) < r_pend) begin
        w_push_data[j*ELEM_WIDTH +: ELEM_WIDTH] = r_pack[j];
      end
    end
  end

  assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  // Words whose RAM write completed before this edge and survive the pop.
  assign w_avail      = r_count - CNT_W'(w_pop);
  assign w_rd_addr    = r_rd_ptr + c_aw'(w_pop);

  result_pack_store #(
    .DATA_W (c_ram_w),
    .DEPTH  (DEPTH),
    .ADDR_W (c_aw)
  ) u_store (
    .i_clk     (i_clk),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({w_push_lanes, w_push_data}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int j = 0; j < PACK; j++) begin
        r_pack[j] <= '0;
      end
      r_pend       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_full       <= 1'b0;
      r_afull      <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
        r_pend   <= '0;
      end else if (i_wr_en && !w_push_req) begin
        for (int j = 0; j < PACK; j++) begin
          if (LANE_W'(j) == r_pend) begin
            r_pack[j] <= i_wr_data;
          end
        end
        r_pend <= r_pend + LANE_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      r_count      <= w_count_next;
      r_full       <= (w_count_next == c_depth);
      r_afull      <= (w_count_next >= c_afull_lvl);
      r_head_valid <= (w_avail != '0);
      r_overflow   <= w_drop | (r_overflow & ~i_clr_err);
      r_underflow  <= w_underrun | (r_underflow & ~i_clr_err);
    end
  end

  assign o_rd_data    = r_head_valid ? w_ram_q[WORD_W-1:0] : '0;
  assign o_rd_lanes   = r_head_valid ? w_ram_q[c_ram_w-1:WORD_W] : '0;
  assign o_empty      = ~r_head_valid;
  assign o_full       = r_full;
  assign o_afull      = r_afull;
  assign o_word_count = r_count;
  assign o_pend_lanes = r_pend;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    r_count <= c_depth);
  a_head_lanes: assert property (@(posedge i_clk) disable iff (i_reset)
    r_head_valid |-> (o_rd_lanes != '0));

endmodule
`default_nettype wire

// File: tb/tb_result_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_pack_buffer
// Description : Self-checking bench for result_pack_buffer (PACK=4, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_pack_buffer;

  localparam int EW = 16;
  localparam int PK = 4;
  localparam int DP = 8;
  localparam int AM = 2;
  localparam int WW = EW * PK;
  localparam int LW = $clog2(PK + 1);
  localparam int CW = $clog2(DP + 1);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [EW-1:0] i_wr_data;
  logic          i_wr_en;
  logic          i_flush;
  logic          i_rd_en;
  logic          i_clr_err;
  logic          o_full;
  logic          o_afull;
  logic [WW-1:0] o_rd_data;
  logic [LW-1:0] o_rd_lanes;
  logic          o_empty;
  logic [CW-1:0] o_word_count;
  logic [LW-1:0] o_pend_lanes;
  logic          o_overflow;
  logic          o_underflow;

  always #5 i_clk = ~i_clk;

  result_pack_buffer #(
    .ELEM_WIDTH   (EW),
    .PACK         (PK),
    .DEPTH        (DP),
    .AFULL_MARGIN (AM)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_data    (i_wr_data),
    .i_wr_en      (i_wr_en),
    .i_flush      (i_flush),
    .o_full       (o_full),
    .o_afull      (o_afull),
    .o_rd_data    (o_rd_data),
    .o_rd_lanes   (o_rd_lanes),
    .i_rd_en      (i_rd_en),
    .o_empty      (o_empty),
    .o_word_count (o_word_count),
    .o_pend_lanes (o_pend_lanes),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow),
    .i_clr_err    (i_clr_err)
  );

  // Reference model: a queue of stored words tagged with their push edge,
  // plus the list of pending elements.
  typedef struct {
    int          lanes;
    logic [63:0] data;
    int          t;
  } mword_t;

  mword_t      mq[$];
  logic [15:0] mpend[$];
  bit          movf;
  bit          munf;
  int          edge_n;
  int          n_checks;
  int          n_fail;
  logic [15:0] elems[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_vis();
    return (mq.size() > 0) && (mq[0].t < edge_n);
  endfunction

  task automatic check_all(input string tag);
    bit          v;
    logic [63:0] ed;
    int          el;
    v  = m_vis();
    ed = 64'd0;
    el = 0;
    if (v) begin
      ed = mq[0].data;
      el = mq[0].lanes;
    end
    chk({tag, "/empty"}, 64'(o_empty), 64'(!v));
    chk({tag, "/rd_data"}, 64'(o_rd_data), ed);
    chk({tag, "/rd_lanes"}, 64'(o_rd_lanes), 64'(el));
    chk({tag, "/count"}, 64'(o_word_count), 64'(mq.size()));
    chk({tag, "/pend"}, 64'(o_pend_lanes), 64'(mpend.size()));
    chk({tag, "/full"}, 64'(o_full), 64'(mq.size() == DP));
    chk({tag, "/afull"}, 64'(o_afull), 64'(mq.size() >= DP - AM));
    chk({tag, "/ovf"}, 64'(o_overflow), 64'(movf));
    chk({tag, "/unf"}, 64'(o_underflow), 64'(munf));
  endtask

  task automatic step(input bit wr, input logic [15:0] d, input bit fl,
                      input bit rd, input bit clr, input string tag);
    bit          vis;
    bit          pop;
    bit          req;
    bit          ok;
    int          nel;
    logic [63:0] pw;
    @(negedge i_clk);
    i_wr_en   = wr;
    i_wr_data = d;
    i_flush   = fl;
    i_rd_en   = rd;
    i_clr_err = clr;
    vis = m_vis();
    pop = rd && vis;
    nel = mpend.size() + (wr ? 1 : 0);
    req = (wr && mpend.size() == PK - 1) || (fl && nel > 0);
    ok  = req && (mq.size() < DP || pop);
    pw  = 64'd0;
    for (int j = 0; j < mpend.size(); j++) pw |= 64'(mpend[j]) << (16 * j);
    if (wr) pw |= 64'(d) << (16 * mpend.size());
    @(posedge i_clk);
    edge_n++;
    if (pop) void'(mq.pop_front());
    if (ok) begin
      mq.push_back('{nel, pw, edge_n});
      mpend.delete();
    end else if (wr && !req) begin
      mpend.push_back(d);
    end
    movf = (req && !ok) ? 1'b1 : (clr ? 1'b0 : movf);
    munf = (rd && !vis) ? 1'b1 : (clr ? 1'b0 : munf);
    #1;
    i_wr_en   = 1'b0;
    i_flush   = 1'b0;
    i_rd_en   = 1'b0;
    i_clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    mpend.delete();
    movf = 1'b0;
    munf = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    n_checks  = 0;
    n_fail    = 0;
    edge_n    = 0;
    i_wr_data = '0;
    i_wr_en   = 1'b0;
    i_flush   = 1'b0;
    i_rd_en   = 1'b0;
    i_clr_err = 1'b0;
    i_reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Four FP16 values pack into one full word.
    step(1, 16'h3C00, 0, 0, 0, "w0");
    step(1, 16'h4000, 0, 0, 0, "w1");
    step(1, 16'h4200, 0, 0, 0, "w2");
    step(1, 16'h4400, 0, 0, 0, "w3");
    chk("pack4_not_yet", 64'(o_empty), 64'd1);
    step(0, 0, 0, 0, 0, "idle0");
    chk("pack4_data", 64'(o_rd_data), 64'h4400_4200_4000_3C00);
    chk("pack4_lanes", 64'(o_rd_lanes), 64'd4);
    step(0, 0, 0, 1, 0, "pop0");

    // Partial flush with a same-cycle write, then an empty flush.
    step(1, 16'h1111, 0, 0, 0, "p0");
    step(1, 16'h2222, 0, 0, 0, "p1");
    step(1, 16'h3333, 1, 0, 0, "p2flush");
    step(0, 0, 1, 0, 0, "emptyflush");
    chk("emptyflush_count", 64'(o_word_count), 64'd1);
    chk("partial_data", 64'(o_rd_data), 64'h0000_3333_2222_1111);
    chk("partial_lanes", 64'(o_rd_lanes), 64'd3);
    step(0, 0, 0, 1, 0, "pop1");

    // Fill to DEPTH, watching the almost-full threshold.
    for (int w = 1; w <= DP; w++) begin
      for (int e = 0; e < PK; e++) begin
        r = 16'($urandom);
        step(1, r, 0, 0, 0, "fill");
      end
      if (w == DP - AM - 1) chk("afull_below", 64'(o_afull), 64'd0);
      if (w == DP - AM) chk("afull_at", 64'(o_afull), 64'd1);
    end
    chk("full_set", 64'(o_full), 64'd1);
    for (int e = 0; e < PK - 1; e++) step(1, 16'($urandom), 0, 0, 0, "pend_full");
    step(1, 16'hDEAD, 0, 0, 0, "ovf_write");
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    chk("ovf_pend", 64'(o_pend_lanes), 64'd3);
    chk("ovf_count", 64'(o_word_count), 64'd8);
    step(1, 16'hBEEF, 0, 1, 0, "pop_and_push");
    chk("popush_count", 64'(o_word_count), 64'd8);
    chk("popush_pend", 64'(o_pend_lanes), 64'd0);
    step(0, 0, 0, 0, 1, "clr_ovf");
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    for (int p = 0; p < DP; p++) step(0, 0, 0, 1, 0, "drain");
    step(0, 0, 0, 1, 0, "unf_pop0");
    chk("unf_flag0", 64'(o_underflow), 64'd1);
    step(0, 0, 0, 0, 1, "clr_unf0");

    // Five words, then back-to-back pops against the written elements.
    elems.delete();
    for (int e = 0; e < 5 * PK; e++) begin
      r = 16'($urandom);
      elems.push_back(r);
      step(1, r, 0, 0, 0, "five");
    end
    step(0, 0, 0, 0, 0, "five_idle");
    for (int p = 0; p < 5; p++) begin
      chk("b2b_valid", 64'(o_empty), 64'd0);
      chk("b2b_data", 64'(o_rd_data),
          {elems[4*p+3], elems[4*p+2], elems[4*p+1], elems[4*p]});
      step(0, 0, 0, 1, 0, "b2b_pop");
    end
    step(0, 0, 0, 1, 0, "unf_pop1");
    chk("unf_flag1", 64'(o_underflow), 64'd1);
    step(0, 0, 0, 0, 1, "clr_unf1");
    chk("unf_cleared", 64'(o_underflow), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0,
           ($urandom % 3) == 0, ($urandom % 16) == 0, "rand");
    end

    // Asynchronous reset mid-stream with count=3, pend=2.
    for (int p = 0; p < 20; p++) step(0, 0, 1, 1, 1, "predrain");
    for (int p = 0; p < 12; p++) step(0, 0, 0, 1, 0, "drain2");
    for (int e = 0; e < 3 * PK + 2; e++) step(1, 16'($urandom), 0, 0, 0, "prerst");
    step(0, 0, 0, 0, 0, "prerst_idle");
    chk("prerst_count", 64'(o_word_count), 64'd3);
    chk("prerst_pend", 64'(o_pend_lanes), 64'd2);
    @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    step(1, 16'hABCD, 0, 0, 0, "post_rst_w");
    step(0, 0, 1, 0, 0, "post_rst_flush");
    step(0, 0, 0, 0, 0, "post_rst_idle");
    chk("post_rst_lane0", 64'(o_rd_data), 64'h0000_0000_0000_ABCD);
    chk("post_rst_lanes", 64'(o_rd_lanes), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
